rr_arbiter8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Each cycle a priority encoder picks the winner from the 8-bit request vector.
- The search starting point rotates past the last winner, so no requester starves.
- Drives a one-hot grant, the encoded 3-bit grant index and a grant-valid flag to the shared resource. It is the sequencing layer above the team's 8:3 encoder.

---
 rtl/rr_arbiter8_if.sv | 28 ++
 rtl/rr_arbiter8.sv | 134 +++++++++++++
 tb/tb_rr_arbiter8.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/rr_arbiter8_if.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8_if
// Description : Request/grant bundle between the requesters and rr_arbiter8.
//               The master side drives en/req/done. The slave side (the
//               arbiter) drives the grant outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface rr_arbiter8_if;
   logic       en;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_vld;
   logic       timeout;

   modport master (
      output en, req, done,
      input  gnt, gnt_idx, gnt_vld, timeout
   );

   modport slave (
      input  en, req, done,
      output gnt, gnt_idx, gnt_vld, timeout
   );
endinterface : rr_arbiter8_if
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter8
// Description : Eight-way round-robin arbiter. The priority search starts one
//               position past the previous winner and wraps from 7 to 0.
//               Grants are registered, and an idle cycle always separates
//               two consecutive grants.
//               Optional macro ARB_TIMEOUT_EN adds a hold limit of MAX_HOLD
//               cycles, with a one-cycle timeout pulse on forced release.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16
) (
   input  wire          clk,
   input  wire          rst,
   rr_arbiter8_if.slave bus
);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t     r_state;
   logic [2:0] r_last_idx;
   logic [7:0] r_gnt;
   logic [2:0] r_gnt_idx;
   logic       r_gnt_vld;
   logic       r_timeout;

   logic [2:0] w_win_idx;
   logic       w_win_vld;
   logic [2:0] w_cand;
   logic       w_release;

   // An out-of-range hold limit is rejected at elaboration.
   if ((MAX_HOLD < 1) || (MAX_HOLD > 255)) begin : g_bad_max_hold
      $error("rr_arbiter8: MAX_HOLD out of range 1..255");
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);
   logic [7:0] r_hold_cnt;
`endif

   // Cyclic priority search starting just past the previous winner. The
   // loop scans from the farthest offset down, so the nearest set bit is
   // the last one written and therefore wins.
   always_comb begin
      w_win_idx = 3'd0;
      w_win_vld = 1'b0;
      w_cand    = 3'd0;
      for (int off = 7; off >= 0; off--) begin
         w_cand = r_last_idx + 3'd1 + 3'(off);
         if (bus.req[w_cand]) begin
            w_win_idx = w_cand;
            w_win_vld = 1'b1;
         end
      end
   end

   // The owner releases by asserting done or by dropping its own request.
   // When both happen in the same cycle they count as one release.
   assign w_release = bus.done | ~bus.req[r_gnt_idx];

   // Arbiter FSM with registered grant outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_last_idx <= 3'd7;
         r_gnt      <= 8'h00;
         r_gnt_idx  <= 3'd0;
         r_gnt_vld  <= 1'b0;
         r_timeout  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_hold_cnt <= 8'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               r_timeout <= 1'b0;
               if (bus.en && w_win_vld) begin
                  r_state   <= GRANT;
                  r_gnt     <= 8'd1 << w_win_idx;
                  r_gnt_idx <= w_win_idx;
                  r_gnt_vld <= 1'b1;
`ifdef ARB_TIMEOUT_EN
                  r_hold_cnt <= 8'd0;
`endif
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_state    <= IDLE;
                  r_last_idx <= r_gnt_idx;
                  r_gnt      <= 8'h00;
                  r_gnt_idx  <= 3'd0;
                  r_gnt_vld  <= 1'b0;
                  r_timeout  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
               end else if (r_hold_cnt == c_hold_last) begin
                  // Forced release. A normal release in the same cycle
                  // takes the branch above and is reported as normal.
                  r_state    <= IDLE;
                  r_last_idx <= r_gnt_idx;
                  r_gnt      <= 8'h00;
                  r_gnt_idx  <= 3'd0;
                  r_gnt_vld  <= 1'b0;
                  r_timeout  <= 1'b1;
               end else begin
                  r_hold_cnt <= r_hold_cnt + 8'd1;
`endif
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = r_gnt;
   assign bus.gnt_idx = r_gnt_idx;
   assign bus.gnt_vld = r_gnt_vld;
`ifdef ARB_TIMEOUT_EN
   assign bus.timeout = r_timeout;
`else
   // Without the hold limit there is never a forced release.
   assign bus.timeout = 1'b0;
`endif

endmodule : rr_arbiter8
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`default_nettype none
// ============================================================================
// Module      : tb_rr_arbiter8
// Description : Scoreboard bench for rr_arbiter8. Each driven cycle advances
//               an integer-level reference model and queues the expected
//               outputs. A monitor compares them after the next edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter8;

   localparam int TB_MAX_HOLD = 4;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] idx;
      logic       vld;
      logic       tmo;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   rr_arbiter8_if bus ();

   rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   // Reference state: owner is the current grant holder, or -1 when idle.
   int   m_owner;
   int   m_last;
   int   m_hold;
   bit   m_tmo;

   // Apply one clock edge of the arbitration rules to the model.
   task automatic model_edge(input logic r, input logic e, input logic [7:0] q, input logic d);
      if (r) begin
         m_owner = -1;
         m_last  = 7;
         m_hold  = 0;
         m_tmo   = 1'b0;
      end else if (m_owner < 0) begin
         m_tmo = 1'b0;
         if (e && (q != 8'h00)) begin
            for (int i = 1; i <= 8; i++) begin
               if ((m_owner < 0) && q[(m_last + i) % 8]) m_owner = (m_last + i) % 8;
            end
            m_hold = 0;
         end
      end else if (d || !q[m_owner]) begin
         m_last  = m_owner;
         m_owner = -1;
         m_tmo   = 1'b0;
      end else begin
`ifdef ARB_TIMEOUT_EN
         if (m_hold == TB_MAX_HOLD - 1) begin
            m_last  = m_owner;
            m_owner = -1;
            m_tmo   = 1'b1;
         end else begin
            m_hold++;
         end
`endif
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs it should produce.
   task automatic step(input logic r, input logic e, input logic [7:0] q, input logic d);
      exp_t ex;
      @(negedge clk);
      rst      = r;
      bus.en   = e;
      bus.req  = q;
      bus.done = d;
      model_edge(r, e, q, d);
      ex.vld = (m_owner >= 0);
      ex.gnt = (m_owner >= 0) ? (8'd1 << m_owner) : 8'h00;
      ex.idx = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
      ex.tmo = m_tmo;
      exp_q.push_back(ex);
   endtask

   // Monitor: the arbiter presents outputs every cycle. Compare each one
   // against the oldest queued expectation.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            compared++;
            if ((bus.gnt !== ex.gnt) || (bus.gnt_idx !== ex.idx) ||
                (bus.gnt_vld !== ex.vld) || (bus.timeout !== ex.tmo)) begin
               mismatched++;
               $display("FAIL outputs cyc=%0d: got gnt=%h idx=%0d vld=%b tmo=%b, need gnt=%h idx=%0d vld=%b tmo=%b",
                        cyc, bus.gnt, bus.gnt_idx, bus.gnt_vld, bus.timeout,
                        ex.gnt, ex.idx, ex.vld, ex.tmo);
            end
         end
      end
   end

   initial begin
      logic [7:0] rq;
      rst      = 1'b1;
      bus.en   = 1'b1;
      bus.req  = 8'hFF;
      bus.done = 1'b0;

      // Reset held with everything requesting, then the first grant.
      step(1, 1, 8'hFF, 0);
      step(1, 1, 8'hFF, 0);
      step(0, 1, 8'hFF, 0);
      step(0, 1, 8'hFF, 1);
      // Rotation: all requesting, done held high so each grant lasts one cycle.
      repeat (18) step(0, 1, 8'hFF, 1);
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h00, 0);

      // Wrap and skip: grant 5 and release it, then the sparse patterns.
      step(1, 1, 8'h00, 0);
      step(0, 1, 8'h20, 0);
      step(0, 1, 8'h20, 0);
      step(0, 1, 8'h20, 1);
      step(0, 1, 8'h06, 0);
      step(0, 1, 8'h06, 0);
      step(0, 1, 8'h46, 0);
      step(0, 1, 8'h46, 1);
      step(0, 1, 8'h46, 0);
      step(0, 1, 8'h46, 1);
      step(0, 1, 8'h46, 0);
      step(0, 1, 8'h00, 0);

      // Release by request drop, then en low during a grant.
      step(0, 1, 8'h08, 0);
      step(0, 1, 8'h08, 0);
      step(0, 1, 8'h00, 0);
      step(0, 1, 8'h08, 0);
      step(0, 1, 8'h08, 0);
      step(0, 0, 8'h08, 0);
      step(0, 0, 8'h0C, 0);
      step(0, 0, 8'h08, 1);
      step(0, 0, 8'hFF, 0);
      step(0, 1, 8'h00, 0);

      // Reset in the middle of a grant to index 4.
      step(1, 1, 8'h00, 0);
      step(0, 1, 8'h10, 0);
      step(0, 1, 8'h10, 0);
      step(1, 1, 8'h10, 0);
      step(0, 1, 8'hFF, 0);
      step(0, 1, 8'hFF, 1);
      step(0, 1, 8'h00, 0);

      // A lone requester holding its grant without done; it times out in
      // the hold-limit build and stays granted otherwise.
      repeat (16) step(0, 1, 8'h01, 0);
      // done and a request drop together count as one release.
      step(0, 1, 8'h00, 1);
      step(0, 1, 8'h00, 0);

      // Randomized traffic with occasional reset.
      for (int n = 0; n < 2000; n++) begin
         rq = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rq = 8'h00;
         step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) != 0), rq,
              ($urandom_range(0, 3) == 0));
      end

      step(0, 0, 8'h00, 0);
      @(posedge clk);
      #3;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d queued entries left, need 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule : tb_rr_arbiter8
`default_nettype wire
